// File: rtl/score_bcd_tracker.sv
// Saturating score accumulator with a frame-synchronous binary-to-BCD
// (double-dabble) converter feeding latched display digits.
module score_bcd_tracker #(
   parameter int unsigned MAX_SCORE  = 99999,
   parameter int unsigned SHIFT_BITS = 17
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        add_valid,
   input  logic [7:0]  add_value,
   input  logic        clear,
   input  logic        frame_tick,
   output logic [31:0] score,
   output logic [3:0]  dig_10000s,
   output logic [3:0]  dig_1000s,
   output logic [3:0]  dig_100s,
   output logic [3:0]  dig_10s,
   output logic [3:0]  dig_1s,
   output logic        digits_upd,
   output logic        busy,
   output logic        sat
);

   localparam int unsigned SUM_W = SHIFT_BITS + 1;
   localparam int unsigned BCD_W = 20;
   localparam int unsigned CNT_W = $clog2(SHIFT_BITS + 1);
   localparam logic [SHIFT_BITS-1:0] MAX_VAL = SHIFT_BITS'(MAX_SCORE);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [SHIFT_BITS-1:0] score_q, score_d;
   logic                  sat_q, sat_d;
   logic [SUM_W-1:0]      sum;
   logic [SHIFT_BITS-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
   logic [BCD_W-1:0]      dig_q, dig_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  upd_q, upd_d;
   logic                  busy_q, busy_d;

   // Accumulator runs independently of the converter; clear wins over add.
   always_comb begin
      sum     = SUM_W'(score_q) + SUM_W'(add_value);
      score_d = score_q;
      if (clear) begin
         score_d = '0;
      end else if (add_valid) begin
         score_d = (sum > SUM_W'(MAX_VAL)) ? MAX_VAL : sum[SHIFT_BITS-1:0];
      end
      sat_d = (score_d == MAX_VAL);
   end

   // Add-3 correction on every nibble that would overflow after the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Next-state and converter datapath.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      upd_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_tick) begin
               bin_d   = score_q;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SHIFT_BITS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            dig_d   = bcd_q;
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         score_q <= '0;
         sat_q   <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         sat_q   <= sat_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         upd_q   <= upd_d;
         busy_q  <= busy_d;
      end
   end

   assign score      = 32'(score_q);
   assign sat        = sat_q;
   assign busy       = busy_q;
   assign digits_upd = upd_q;
   assign dig_10000s = dig_q[19:16];
   assign dig_1000s  = dig_q[15:12];
   assign dig_100s   = dig_q[11:8];
   assign dig_10s    = dig_q[7:4];
   assign dig_1s     = dig_q[3:0];

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Directed bench for score_bcd_tracker: accumulation, saturation, conversion
// latency, ignored frame ticks, clear priority and mid-conversion reset.
module tb_score_bcd_tracker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        add_valid;
   logic [7:0]  add_value;
   logic        clear;
   logic        frame_tick;
   logic [31:0] score;
   logic [3:0]  dig_10000s, dig_1000s, dig_100s, dig_10s, dig_1s;
   logic        digits_upd;
   logic        busy;
   logic        sat;

   int vectors     = 0;
   int miscompares = 0;

   score_bcd_tracker dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .add_valid  (add_valid),
      .add_value  (add_value),
      .clear      (clear),
      .frame_tick (frame_tick),
      .score      (score),
      .dig_10000s (dig_10000s),
      .dig_1000s  (dig_1000s),
      .dig_100s   (dig_100s),
      .dig_10s    (dig_10s),
      .dig_1s     (dig_1s),
      .digits_upd (digits_upd),
      .busy       (busy),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] digits();
      return {dig_10000s, dig_1000s, dig_100s, dig_10s, dig_1s};
   endfunction

   // One rising edge; returns on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_add(input logic [7:0] v);
      add_valid = 1'b1;
      add_value = v;
      step();
      add_valid = 1'b0;
      add_value = 8'd0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Fires frame_tick and watches 40 edges; first_edge counts from the sampling edge.
   task automatic run_frame(output int first_edge, output int pulses, output int busy_cnt);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      busy_cnt   = busy ? 1 : 0;
      first_edge = -1;
      pulses     = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (busy) busy_cnt++;
         if (digits_upd) begin
            pulses++;
            if (first_edge < 0) first_edge = i;
         end
      end
   endtask

   task automatic test_reset();
      int fe, pu, bc;
      reset_n = 1'b0; add_valid = 1'b0; add_value = 8'd0; clear = 1'b0; frame_tick = 1'b0;
      step(); step();
      vectors++;
      if (score !== 32'd0 || digits() !== 20'h00000 || digits_upd !== 1'b0 ||
          busy !== 1'b0 || sat !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: score=%0d dig=%h upd=%b busy=%b sat=%b, want all 0",
                  score, digits(), digits_upd, busy, sat);
      end
      reset_n = 1'b1;
      step();
      run_frame(fe, pu, bc);
      vectors++;
      if (bc !== 18) begin
         miscompares++; $display("FAIL reset_busy_len: got %0d cycles, want 18", bc);
      end
      vectors++;
      if (fe !== 18 || pu !== 1) begin
         miscompares++; $display("FAIL reset_latency: edge=%0d pulses=%0d, want 18/1", fe, pu);
      end
      vectors++;
      if (digits() !== 20'h00000) begin
         miscompares++; $display("FAIL reset_digits: got %h want 00000", digits());
      end
   endtask

   task automatic test_add_convert();
      int fe, pu, bc;
      repeat (5) do_add(8'd255);
      vectors++;
      if (score !== 32'd1275 || sat !== 1'b0) begin
         miscompares++; $display("FAIL add_score: got %0d sat=%b want 1275 sat=0", score, sat);
      end
      run_frame(fe, pu, bc);
      vectors++;
      if (fe !== 18 || pu !== 1 || digits() !== 20'h01275) begin
         miscompares++;
         $display("FAIL add_digits: edge=%0d pulses=%0d dig=%h want 18/1/01275", fe, pu, digits());
      end
   endtask

   task automatic test_saturate();
      int fe, pu, bc;
      do_clear();
      repeat (392) do_add(8'd255);
      do_add(8'd30);
      vectors++;
      if (score !== 32'd99990 || sat !== 1'b0) begin
         miscompares++; $display("FAIL sat_pre: got %0d sat=%b want 99990 sat=0", score, sat);
      end
      do_add(8'd20);
      vectors++;
      if (score !== 32'd99999 || sat !== 1'b1) begin
         miscompares++; $display("FAIL sat_clamp: got %0d sat=%b want 99999 sat=1", score, sat);
      end
      run_frame(fe, pu, bc);
      vectors++;
      if (pu !== 1 || digits() !== 20'h99999) begin
         miscompares++; $display("FAIL sat_digits: pulses=%0d dig=%h want 1/99999", pu, digits());
      end
      do_add(8'd1);
      vectors++;
      if (score !== 32'd99999 || sat !== 1'b1) begin
         miscompares++; $display("FAIL sat_hold: got %0d sat=%b want 99999 sat=1", score, sat);
      end
   endtask

   task automatic test_back_to_back();
      int fe, pu, bc;
      do_clear();
      do_add(8'd42);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      fe = -1; pu = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) begin
            add_valid = 1'b1; add_value = 8'd8; frame_tick = 1'b1;
         end
         step();
         add_valid = 1'b0; add_value = 8'd0; frame_tick = 1'b0;
         if (digits_upd) begin
            pu++;
            if (fe < 0) fe = i;
         end
      end
      vectors++;
      if (fe !== 18 || pu !== 1 || digits() !== 20'h00042) begin
         miscompares++;
         $display("FAIL b2b_snapshot: edge=%0d pulses=%0d dig=%h want 18/1/00042", fe, pu, digits());
      end
      vectors++;
      if (score !== 32'd50) begin
         miscompares++; $display("FAIL b2b_score: got %0d want 50", score);
      end
      run_frame(fe, pu, bc);
      vectors++;
      if (pu !== 1 || digits() !== 20'h00050) begin
         miscompares++; $display("FAIL b2b_next: pulses=%0d dig=%h want 1/00050", pu, digits());
      end
   endtask

   task automatic test_clear_priority();
      do_clear();
      do_add(8'd250);
      do_add(8'd250);
      vectors++;
      if (score !== 32'd500) begin
         miscompares++; $display("FAIL clr_setup: got %0d want 500", score);
      end
      clear = 1'b1; add_valid = 1'b1; add_value = 8'd10;
      step();
      clear = 1'b0; add_valid = 1'b0; add_value = 8'd0;
      vectors++;
      if (score !== 32'd0 || sat !== 1'b0) begin
         miscompares++; $display("FAIL clr_priority: got %0d sat=%b want 0 sat=0", score, sat);
      end
   endtask

   task automatic test_reset_mid();
      int pu, bc;
      do_add(8'd200);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (5) step();
      reset_n = 1'b0;
      #1;
      vectors++;
      if (score !== 32'd0 || digits() !== 20'h00000 || digits_upd !== 1'b0 ||
          busy !== 1'b0 || sat !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: score=%0d dig=%h upd=%b busy=%b sat=%b, want all 0",
                  score, digits(), digits_upd, busy, sat);
      end
      step();
      reset_n = 1'b1;
      pu = 0; bc = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (digits_upd) pu++;
         if (busy) bc++;
      end
      vectors++;
      if (pu !== 0 || bc !== 0 || score !== 32'd0 || digits() !== 20'h00000) begin
         miscompares++;
         $display("FAIL mid_idle: pulses=%0d busy_cycles=%0d score=%0d dig=%h want 0/0/0/00000",
                  pu, bc, score, digits());
      end
      do_add(8'd7);
      vectors++;
      if (score !== 32'd7) begin
         miscompares++; $display("FAIL mid_resume: got %0d want 7", score);
      end
   endtask

   initial begin
      test_reset();
      test_add_convert();
      test_saturate();
      test_back_to_back();
      test_clear_priority();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
